// File: rtl/axis_width_downsizer.sv
// AXI-Stream width downsizer: each IN_WIDTH beat is re-emitted as RATIO OUT_WIDTH beats,
// least-significant slice first, one narrow beat per clock with tlast on the final slice.
module axis_width_downsizer #(
    parameter int IN_WIDTH  = 1024,
    parameter int OUT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   S_AXIS_tvalid,
    output logic                   S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]    S_AXIS_tdata,
    input  logic                   S_AXIS_tlast,
    output logic                   M_AXIS_tvalid,
    input  logic                   M_AXIS_tready,
    output logic [OUT_WIDTH-1:0]   M_AXIS_tdata,
    output logic [OUT_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                   M_AXIS_tlast,
    output logic [31:0]            pkt_count,
    output logic [0:0]             dbg_state
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
        $error("axis_width_downsizer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
    end

    logic [0:0]          state;
    logic [IN_WIDTH-1:0] data_buf;
    logic                buf_last;
    logic [IDX_W-1:0]    idx;
    logic                s_hs;
    logic                m_hs;
    logic                final_hs;

    // Handshakes: a beat transfers on a rising clk edge where tvalid && tready; a valid
    // beat and its payload stay stable until taken, and ready never waits on valid.
    assign m_hs          = (state == ST_DRAIN) && M_AXIS_tready;
    assign final_hs      = m_hs && (idx == LAST_IDX);
    assign S_AXIS_tready = (state == ST_EMPTY) || final_hs;
    assign s_hs          = S_AXIS_tvalid && S_AXIS_tready;

    assign M_AXIS_tvalid = (state == ST_DRAIN);
    assign M_AXIS_tlast  = (state == ST_DRAIN) && buf_last && (idx == LAST_IDX);
    assign M_AXIS_tkeep  = '1;
    assign dbg_state     = state;

    always_comb begin
        M_AXIS_tdata = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx == IDX_W'(i)) begin
                M_AXIS_tdata = data_buf[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            data_buf  <= '0;
            buf_last  <= 1'b0;
            idx       <= '0;
            pkt_count <= '0;
        end else begin
            // A new wide beat may load in the same cycle the last slice leaves.
            if (s_hs) begin
                state    <= ST_DRAIN;
                data_buf <= S_AXIS_tdata;
                buf_last <= S_AXIS_tlast;
                idx      <= '0;
            end else if (final_hs) begin
                state <= ST_EMPTY;
                idx   <= '0;
            end else if (m_hs) begin
                idx <= idx + 1'b1;
            end

            if (final_hs && buf_last) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_width_downsizer.sv
// Directed and random bench for axis_width_downsizer at 256->64 bits: wide beats feed a
// slice scoreboard that a negedge monitor drains against the narrow output stream.
module tb_axis_width_downsizer;
    localparam int IW = 256;
    localparam int OW = 64;
    localparam int W  = OW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          S_AXIS_tvalid = 1'b0;
    logic          S_AXIS_tready;
    logic [IW-1:0] S_AXIS_tdata = '0;
    logic          S_AXIS_tlast = 1'b0;
    logic          M_AXIS_tvalid;
    logic          M_AXIS_tready = 1'b1;
    logic [OW-1:0] M_AXIS_tdata;
    logic [OW/8-1:0] M_AXIS_tkeep;
    logic          M_AXIS_tlast;
    logic [31:0]   pkt_count;
    logic [0:0]    dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    logic [W-1:0] exp_q[$];
    int           hs_cyc[$];
    logic [1:0]   slice_cnt = '0;
    logic [31:0]  exp_pkts = '0;
    int           tlast_seen = 0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_beat = '0;

    axis_width_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
        .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready),
        .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tkeep(M_AXIS_tkeep),
        .M_AXIS_tlast(M_AXIS_tlast), .pkt_count(pkt_count), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        M_AXIS_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        total++;
        bad++;
        $display("FAIL %s observed=timeout expected=completion", tag);
    endtask

    function automatic logic [IW-1:0] rand_wide();
        logic [IW-1:0] v;
        for (int i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // driver: offer one wide beat, push its four slices once acceptance is certain
    task automatic send_beat(input logic [IW-1:0] d, input logic l);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = d;
        S_AXIS_tlast  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            if (S_AXIS_tready) begin
                for (int s = 0; s < 4; s++) exp_q.push_back({l && (s == 3), d[s*OW +: OW]});
                @(posedge clk);
                #1;
                S_AXIS_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        S_AXIS_tvalid = 1'b0;
        timeout_fail("s_accept");
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout_fail("drain");
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("m_tvalid", IW'(M_AXIS_tvalid), IW'(exp_q.size() != 0));
            chk("s_tready", IW'(S_AXIS_tready),
                IW'((exp_q.size() == 0) || (M_AXIS_tready && slice_cnt == 2'd3)));
            if (prev_stall) chk("stall_hold", IW'({M_AXIS_tlast, M_AXIS_tdata}), IW'(prev_beat));
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", IW'({M_AXIS_tlast, M_AXIS_tdata}), '1);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("narrow_beat", IW'({M_AXIS_tlast, M_AXIS_tdata}), IW'(e));
                    if (e[W-1]) begin
                        exp_pkts++;
                        tlast_seen++;
                    end
                end
                hs_cyc.push_back(cyc);
                slice_cnt++;
            end
            prev_stall = M_AXIS_tvalid && !M_AXIS_tready;
            prev_beat  = exp_q.size() != 0 ? exp_q[0] : '0;
            if (prev_stall) prev_beat = {M_AXIS_tlast, M_AXIS_tdata};
        end
    end

    initial begin
        int base;
        int t0;
        logic [IW-1:0] d1;

        // reset state
        #12;
        chk("rst_m_tvalid", IW'(M_AXIS_tvalid), '0);
        chk("rst_m_tdata", IW'(M_AXIS_tdata), '0);
        chk("rst_m_tlast", IW'(M_AXIS_tlast), '0);
        chk("rst_s_tready", IW'(S_AXIS_tready), IW'(1));
        chk("rst_pkt_count", IW'(pkt_count), '0);
        chk("tkeep", IW'(M_AXIS_tkeep), IW'(8'hFF));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single packet, lanes 1111..4444
        d1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        base = hs_cyc.size();
        send_beat(d1, 1'b1);
        wait_drain();
        chk("t1_pkt_count", IW'(pkt_count), IW'(32'd1));
        chk("t1_beats", IW'(hs_cyc.size() - base), IW'(4));

        // 2: three back-to-back wide beats, no bubbles
        base = hs_cyc.size();
        for (int b = 0; b < 3; b++) send_beat(rand_wide(), 1'(b == 2));
        wait_drain();
        chk("t2_beats", IW'(hs_cyc.size() - base), IW'(12));
        if (hs_cyc.size() - base == 12)
            chk("t2_span", IW'(hs_cyc[base + 11] - hs_cyc[base]), IW'(11));
        chk("t2_pkt_count", IW'(pkt_count), IW'(exp_pkts));

        // 3: random downstream backpressure over 1000 wide beats
        rand_ready = 1'b1;
        base = hs_cyc.size();
        for (int b = 0; b < 1000; b++) send_beat(rand_wide(), 1'($urandom_range(0, 1)));
        wait_drain();
        rand_ready = 1'b0;
        chk("t3_beats", IW'(hs_cyc.size() - base), IW'(4000));
        chk("t3_pkt_count", IW'(pkt_count), IW'(exp_pkts));

        // 4: tlast pattern 0,0,1 x10
        base = tlast_seen;
        t0 = int'(pkt_count);
        for (int b = 0; b < 30; b++) send_beat(rand_wide(), 1'((b % 3) == 2));
        wait_drain();
        chk("t4_tlasts", IW'(tlast_seen - base), IW'(10));
        chk("t4_pkt_delta", IW'(int'(pkt_count) - t0), IW'(10));

        // 5: asynchronous reset while slice 2 is presented
        send_beat(rand_wide(), 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        slice_cnt = '0;
        #1;
        chk("t5_async_tvalid", IW'(M_AXIS_tvalid), '0);
        chk("t5_async_tlast", IW'(M_AXIS_tlast), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_pkts = '0;
        chk("t5_pkt_count", IW'(pkt_count), '0);
        send_beat({{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 1'b1);
        wait_drain();
        chk("t5_pkt_after", IW'(pkt_count), IW'(32'd1));

        // 6: pkt_count wrap
        force dut.pkt_count = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.pkt_count;
        exp_pkts = 32'hFFFF_FFFF;
        send_beat(rand_wide(), 1'b1);
        wait_drain();
        chk("t6_wrap", IW'(pkt_count), '0);
        chk("t6_model", IW'(pkt_count), IW'(exp_pkts));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
